// File: rtl/msrv32_wb_arbiter_if.sv
// Bus bundle for the msrv32 write-back arbiter: ALU result input, load response
// input and the registered register-file write port.
interface msrv32_wb_arbiter_if #(
  parameter int LQ_DEPTH = 2
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic             alu_valid_in;
  logic [4:0]       alu_rd_addr_in;
  logic [31:0]      alu_result_in;
  logic             alu_stall_out;

  logic             ld_valid_in;
  logic             ld_ready_out;
  logic [4:0]       ld_rd_addr_in;
  logic [31:0]      ld_data_in;
  logic [2:0]       ld_funct3_in;
  logic [1:0]       ld_byte_off_in;

  logic [4:0]       rd_addr_out;
  logic             wr_en_out;
  logic [31:0]      rd_out;
  logic [CNT_W-1:0] lq_count_out;

  modport master (
    output alu_valid_in, alu_rd_addr_in, alu_result_in,
    output ld_valid_in, ld_rd_addr_in, ld_data_in, ld_funct3_in, ld_byte_off_in,
    input  alu_stall_out, ld_ready_out,
    input  rd_addr_out, wr_en_out, rd_out, lq_count_out
  );

  modport slave (
    input  alu_valid_in, alu_rd_addr_in, alu_result_in,
    input  ld_valid_in, ld_rd_addr_in, ld_data_in, ld_funct3_in, ld_byte_off_in,
    output alu_stall_out, ld_ready_out,
    output rd_addr_out, wr_en_out, rd_out, lq_count_out
  );
endinterface

// File: rtl/msrv32_wb_arbiter.sv
// Write-back arbiter: merges ALU results with extended load results buffered in a
// small FIFO, issuing at most one registered register-file write per cycle.
module msrv32_wb_arbiter #(
  parameter int LQ_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset_in,
  msrv32_wb_arbiter_if.slave   wb
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LQ_DEPTH);

  logic [31:0]      fifo_data_q [LQ_DEPTH];
  logic [31:0]      fifo_data_d [LQ_DEPTH];
  logic [4:0]       fifo_rd_q   [LQ_DEPTH];
  logic [4:0]       fifo_rd_d   [LQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [4:0]       rd_addr_q, rd_addr_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      rd_out_q, rd_out_d;

  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             sel_valid;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_data;

  always_comb begin
    ld_byte = wb.ld_data_in[7:0];
    case (wb.ld_byte_off_in)
      2'd0:    ld_byte = wb.ld_data_in[7:0];
      2'd1:    ld_byte = wb.ld_data_in[15:8];
      2'd2:    ld_byte = wb.ld_data_in[23:16];
      default: ld_byte = wb.ld_data_in[31:24];
    endcase
    ld_half = wb.ld_byte_off_in[1] ? wb.ld_data_in[31:16] : wb.ld_data_in[15:0];

    ld_ext = wb.ld_data_in;
    case (wb.ld_funct3_in)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = wb.ld_data_in;
    endcase
  end

  // Ready and stall look only at the registered count, never at same-cycle pops.
  assign full             = (count_q == FULL_CNT);
  assign empty            = (count_q == '0);
  assign wb.ld_ready_out  = !reset_in && !full;
  assign wb.alu_stall_out = !reset_in && full;
  assign push             = wb.ld_valid_in && wb.ld_ready_out;

  // A full queue wins over the ALU so loads cannot starve behind a busy ALU.
  always_comb begin
    pop       = 1'b0;
    sel_valid = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = 32'd0;
    if (full) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = fifo_rd_q[head_q];
      sel_data  = fifo_data_q[head_q];
    end else if (wb.alu_valid_in) begin
      sel_valid = 1'b1;
      sel_rd    = wb.alu_rd_addr_in;
      sel_data  = wb.alu_result_in;
    end else if (!empty) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = fifo_rd_q[head_q];
      sel_data  = fifo_data_q[head_q];
    end
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_rd_d   = fifo_rd_q;
    if (push) begin
      fifo_data_d[tail_q] = ld_ext;
      fifo_rd_d[tail_q]   = wb.ld_rd_addr_in;
    end
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Writes to x0 still consume their slot but never reach the register file.
  always_comb begin
    wr_en_d   = sel_valid && (sel_rd != 5'd0);
    rd_addr_d = wr_en_d ? sel_rd : 5'd0;
    rd_out_d  = wr_en_d ? sel_data : 32'd0;
  end

  always_ff @(posedge clock) begin
    if (reset_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rd_addr_q <= 5'd0;
      wr_en_q   <= 1'b0;
      rd_out_q  <= 32'd0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      rd_out_q  <= rd_out_d;
    end
  end

  always_ff @(posedge clock) begin
    fifo_data_q <= fifo_data_d;
    fifo_rd_q   <= fifo_rd_d;
  end

  assign wb.rd_addr_out  = rd_addr_q;
  assign wb.wr_en_out    = wr_en_q;
  assign wb.rd_out       = rd_out_q;
  assign wb.lq_count_out = count_q;
endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
// Self-checking bench for msrv32_wb_arbiter: extension table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_msrv32_wb_arbiter;
  localparam int D = 2;

  logic clock = 1'b0;
  logic reset_in;
  int   vectors = 0;
  int   miscompares = 0;

  msrv32_wb_arbiter_if #(.LQ_DEPTH(D)) bus ();

  msrv32_wb_arbiter #(.LQ_DEPTH(D)) dut (
    .clock    (clock),
    .reset_in (reset_in),
    .wb       (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } lq_entry_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] expected;
  } ext_vec_t;

  lq_entry_t   lq[$];
  logic        exp_wr;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  function automatic logic [31:0] refExt(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] data);
    int b;
    int h;
    b = int'((data >> (8 * int'(off))) & 32'hFF);
    h = int'((data >> (16 * int'(off[1]))) & 32'hFFFF);
    case (f3)
      3'b000: return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'b100: return 32'(b);
      3'b001: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'b101: return 32'(h);
      default: return data;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic av, input logic [4:0] ard,
                               input logic [31:0] ares, input logic lv, input logic [4:0] lrd,
                               input logic [31:0] ldat, input logic [2:0] f3, input logic [1:0] off);
    reset_in            = rst;
    bus.alu_valid_in    = av;
    bus.alu_rd_addr_in  = ard;
    bus.alu_result_in   = ares;
    bus.ld_valid_in     = lv;
    bus.ld_rd_addr_in   = lrd;
    bus.ld_data_in      = ldat;
    bus.ld_funct3_in    = f3;
    bus.ld_byte_off_in  = off;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
  endtask

  // Reference: queue of pending loads; full queue beats ALU, ALU beats non-empty queue.
  task automatic modelUpdate();
    int        n;
    logic      can_push;
    logic      sel;
    lq_entry_t e;
    n        = lq.size();
    can_push = (n != D);
    sel      = 1'b0;
    e.rd     = 5'd0;
    e.data   = 32'd0;
    if (reset_in) begin
      lq.delete();
      exp_wr   = 1'b0;
      exp_addr = 5'd0;
      exp_data = 32'd0;
    end else begin
      if (n == D) begin
        e   = lq.pop_front();
        sel = 1'b1;
      end else if (bus.alu_valid_in) begin
        e.rd   = bus.alu_rd_addr_in;
        e.data = bus.alu_result_in;
        sel    = 1'b1;
      end else if (n != 0) begin
        e   = lq.pop_front();
        sel = 1'b1;
      end
      if (bus.ld_valid_in && can_push) begin
        lq_entry_t p;
        p.rd   = bus.ld_rd_addr_in;
        p.data = refExt(bus.ld_funct3_in, bus.ld_byte_off_in, bus.ld_data_in);
        lq.push_back(p);
      end
      exp_wr   = sel && (e.rd != 5'd0);
      exp_addr = exp_wr ? e.rd : 5'd0;
      exp_data = exp_wr ? e.data : 32'd0;
    end
  endtask

  task automatic step();
    logic exp_ready;
    logic exp_stall;
    #2;
    exp_ready = !reset_in && (lq.size() != D);
    exp_stall = !reset_in && (lq.size() == D);
    checkOutput("ld_ready", 32'(bus.ld_ready_out), 32'(exp_ready));
    checkOutput("alu_stall", 32'(bus.alu_stall_out), 32'(exp_stall));
    checkOutput("lq_count", 32'(bus.lq_count_out), 32'(lq.size()));
    @(posedge clock);
    modelUpdate();
    #1;
    checkOutput("wr_en", 32'(bus.wr_en_out), 32'(exp_wr));
    checkOutput("rd_addr", 32'(bus.rd_addr_out), 32'(exp_addr));
    checkOutput("rd_out", bus.rd_out, exp_data);
  endtask

  ext_vec_t tbl[10];

  initial begin
    tbl[0] = '{3'b000, 2'd1, 32'h80FF7F01, 32'h0000007F};
    tbl[1] = '{3'b000, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF};
    tbl[2] = '{3'b100, 2'd3, 32'h80FF7F01, 32'h00000080};
    tbl[3] = '{3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF};
    tbl[4] = '{3'b101, 2'd0, 32'h80FF7F01, 32'h00007F01};
    tbl[5] = '{3'b000, 2'd0, 32'h80FF7F01, 32'h00000001};
    tbl[6] = '{3'b001, 2'd1, 32'h80FF7F01, 32'h00007F01};
    tbl[7] = '{3'b101, 2'd3, 32'h80FF7F01, 32'h000080FF};
    tbl[8] = '{3'b010, 2'd1, 32'h80FF7F01, 32'h80FF7F01};
    tbl[9] = '{3'b011, 2'd0, 32'h80FF7F01, 32'h80FF7F01};

    applyStimulus(1'b1, 1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 32'h5678, 3'b010, 2'd0);
    @(posedge clock);
    #1;

    // Reset held with both producers active.
    for (int i = 0; i < 2; i++) step();
    checkOutput("rst_ready", 32'(bus.ld_ready_out), 32'd0);
    idle();
    #1;
    checkOutput("rel_ready", 32'(bus.ld_ready_out), 32'd1);
    step();

    // ALU path.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
    step();
    checkOutput("alu_wr_en", 32'(bus.wr_en_out), 32'd1);
    checkOutput("alu_addr", 32'(bus.rd_addr_out), 32'd5);
    checkOutput("alu_data", bus.rd_out, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
    step();
    checkOutput("alu_x0_wr_en", 32'(bus.wr_en_out), 32'd0);
    idle();
    step();

    // Extension table.
    foreach (tbl[i]) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, tbl[i].data, tbl[i].f3, tbl[i].off);
      step();
      idle();
      step();
      checkOutput("ext_wr_en", 32'(bus.wr_en_out), 32'd1);
      checkOutput($sformatf("ext[%0d]", i), bus.rd_out, tbl[i].expected);
    end

    // Priority: ALU valid every cycle while two loads fill the queue.
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h100, 1'b1, 5'd7, 32'h11111111, 3'b010, 2'd0);
    step();
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h101, 1'b1, 5'd8, 32'h22222222, 3'b010, 2'd0);
    step();
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h102, 1'b1, 5'd10, 32'h33333333, 3'b010, 2'd0);
    #1;
    checkOutput("prio_stall", 32'(bus.alu_stall_out), 32'd1);
    checkOutput("prio_ready", 32'(bus.ld_ready_out), 32'd0);
    step();
    checkOutput("prio_addr", 32'(bus.rd_addr_out), 32'd7);
    checkOutput("prio_data", bus.rd_out, 32'h11111111);
    idle();
    for (int i = 0; i < 3; i++) step();

    // Simultaneous push/pop across pointer wrap.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h1000, 3'b010, 2'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 2), 32'h01010101 * i + 5, 3'b010, 2'd0);
      step();
      checkOutput("pp_count", 32'(bus.lq_count_out), 32'd1);
      checkOutput("pp_wr_en", 32'(bus.wr_en_out), 32'd1);
    end
    idle();
    for (int i = 0; i < 2; i++) step();

    // Mid-operation reset with a full queue.
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h200, 1'b1, 5'd11, 32'h44444444, 3'b010, 2'd0);
    step();
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h201, 1'b1, 5'd12, 32'h55555555, 3'b010, 2'd0);
    step();
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h202, 1'b1, 5'd13, 32'h66666666, 3'b010, 2'd0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("mrst_wr_en", 32'(bus.wr_en_out), 32'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom(),
                    ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom(),
                    3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
